pool_vector_unit: RTL

POOL_VECTOR_UNIT -- requirements
Module: pool_vector_unit

---
 rtl/pool_vector_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/pool_vector_unit.sv
// ---------------------------------------------------------------------------
// pool_vector_unit
//
// Purpose:
//   Pools a stream of LANES-wide vectors into one result vector per window.
//   A window is a run of accepted beats closed by a beat with op_din_eop.
//   Max pooling keeps the signed maximum of each lane. Average pooling keeps
//   a per-lane sum, scales it by avg_scale (Q fractional bits), rounds it and
//   saturates it to DIN_W. An optional RELU clamp is applied last.
//   Results pass through a 2-stage pipeline into a 2-entry output FIFO.
//
// Configuration macro:
//   POOL_AVG_EN - when defined, builds the average path (sum registers,
//                 multiplier, rounding, saturation, op_sat). When undefined,
//                 mode and avg_scale are ignored, only max pooling is done
//                 and op_sat is tied low.
//
// Ports:
//   clk          in   single rising-edge clock
//   rst          in   asynchronous active-low reset
//   mode         in   0 = max pooling, 1 = average pooling (first beat)
//   avg_scale    in   unsigned reciprocal of window size, Q fractional bits
//   op_din_en    in   input beat valid
//   op_din_eop   in   last beat of the current window
//   op_din       in   LANES x DIN_W lane data, lane i at [i*DIN_W +: DIN_W]
//   op_din_rdy   out  block can accept a beat
//   op_dout_en   out  result valid (FIFO head)
//   op_dout_rdy  in   downstream accepts the result
//   op_dout      out  pooled result, same lane packing as op_din
//   op_sat       out  sticky average-mode saturation flag
// ---------------------------------------------------------------------------
module pool_vector_unit #(
    parameter int LANES = 32,
    parameter int DIN_W = 16,
    parameter int Q     = 13,
    parameter int ACC_W = DIN_W + 8,
    parameter int RELU  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [DIN_W-1:0]       avg_scale,
    input  logic                   op_din_en,
    input  logic                   op_din_eop,
    input  logic [LANES*DIN_W-1:0] op_din,
    output logic                   op_din_rdy,
    output logic                   op_dout_en,
    input  logic                   op_dout_rdy,
    output logic [LANES*DIN_W-1:0] op_dout,
    output logic                   op_sat
);

    localparam int DW = LANES * DIN_W;

    logic          w_accept;
    logic          w_pop;
    logic          r_live;
    logic          r_first;
    logic          r_s1_valid;
    logic          r_s2_valid;
    logic [DW-1:0] w_s2_data;
    logic [DW-1:0] r_s2_data;
    logic [DW-1:0] r_fifo [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic [2:0]    w_occ;

    assign w_accept = op_din_en & op_din_rdy;
    assign w_pop    = op_dout_en & op_dout_rdy;

    // Stage 1 is the accumulator bank itself: after the eop beat the
    // accumulators hold the finished window for one cycle, which is exactly
    // when stage 2 samples them, so a new window may start right away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live     <= 1'b0;
            r_first    <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            if (w_accept) begin
                r_first <= op_din_eop;
            end
            r_s1_valid <= w_accept & op_din_eop;
            r_s2_valid <= r_s1_valid;
        end
    end

`ifdef POOL_AVG_EN
    localparam int PW = ACC_W + DIN_W + 1;
    localparam logic signed [PW-1:0] ROUND_K = PW'(1) << (Q - 1);

    logic             r_mode;
    logic [DIN_W-1:0] r_scale;
    logic [LANES-1:0] w_lane_sat;
    logic             r_sat;

    // Mode is captured on the first beat of a window and the scale on its
    // eop beat; both are then stable while stage 2 consumes the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= 1'b0;
            r_scale <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_accept && r_first) begin
                r_mode <= mode;
            end
            if (w_accept && op_din_eop) begin
                r_scale <= avg_scale;
            end
            if (r_s1_valid && (|w_lane_sat)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign op_sat = r_sat;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{mode, avg_scale, ACC_W[0], Q[0]};
    assign op_sat       = 1'b0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DIN_W-1:0] w_din;
        logic signed [DIN_W-1:0] r_max;
        logic signed [DIN_W-1:0] w_max_next;
        logic signed [DIN_W-1:0] w_pre;
        logic signed [DIN_W-1:0] w_res;

        assign w_din      = op_din[g*DIN_W +: DIN_W];
        assign w_max_next = (r_first || (w_din > r_max)) ? w_din : r_max;

        // Max register: loaded on a first beat, otherwise keeps the maximum.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_max <= '0;
            end else if (w_accept) begin
                r_max <= w_max_next;
            end
        end

`ifdef POOL_AVG_EN
        logic signed [ACC_W-1:0] r_sum;
        logic signed [ACC_W-1:0] w_din_ext;
        logic signed [ACC_W-1:0] w_sum_next;
        logic signed [PW-1:0]    w_prod;
        logic signed [PW-1:0]    w_rnd;
        logic signed [PW-1:0]    w_shr;
        logic                    w_pos_sat;
        logic                    w_neg_sat;
        logic signed [DIN_W-1:0] w_avg;

        assign w_din_ext  = {{(ACC_W-DIN_W){w_din[DIN_W-1]}}, w_din};
        assign w_sum_next = r_first ? w_din_ext : (r_sum + w_din_ext);

        // Sum register wraps naturally at ACC_W bits.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sum <= '0;
            end else if (w_accept) begin
                r_sum <= w_sum_next;
            end
        end

        assign w_prod    = PW'(r_sum) * PW'($signed({1'b0, r_scale}));
        assign w_rnd     = w_prod + ROUND_K;
        assign w_shr     = w_rnd >>> Q;
        assign w_pos_sat = !w_shr[PW-1] && (|w_shr[PW-2:DIN_W-1]);
        assign w_neg_sat = w_shr[PW-1] && !(&w_shr[PW-2:DIN_W-1]);

        // Clamp the rounded average into the signed DIN_W range.
        always_comb begin
            w_avg = w_shr[DIN_W-1:0];
            if (w_pos_sat) begin
                w_avg = {1'b0, {(DIN_W-1){1'b1}}};
            end else if (w_neg_sat) begin
                w_avg = {1'b1, {(DIN_W-1){1'b0}}};
            end
        end

        assign w_pre         = r_mode ? w_avg : r_max;
        assign w_lane_sat[g] = r_mode & (w_pos_sat | w_neg_sat);
`else
        assign w_pre = r_max;
`endif

        assign w_res = ((RELU != 0) && w_pre[DIN_W-1]) ? '0 : w_pre;
        assign w_s2_data[g*DIN_W +: DIN_W] = w_res;
    end

    // Stage 2 holds the finished, clamped result vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_data <= '0;
        end else if (r_s1_valid) begin
            r_s2_data <= w_s2_data;
        end
    end

    // Output FIFO: stage 2 always has a free slot waiting for it because
    // input acceptance is throttled on total occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (r_s2_valid) begin
                r_fifo[r_wr_ptr] <= r_s2_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_s2_valid} - {1'b0, w_pop};
        end
    end

    assign w_occ      = 3'(r_count) + 3'(r_s1_valid) + 3'(r_s2_valid);
    assign op_din_rdy = r_live && (w_occ < 3'd2);
    assign op_dout_en = (r_count != 2'd0);
    assign op_dout    = op_dout_en ? r_fifo[r_rd_ptr] : '0;

endmodule
